fl_checkpoint_stack: RTL

Branch checkpoint store that sits between dispatch and the physical-register free list. It snapshots the free list contents and tail count when a branch dispatches. While a branch is outstanding, it appends every retired T_old to each live snapshot. On a mispredict it drives `free_check_point` / `tail_check_point` / `branch_incorrect` into the free list, so the free list can restore in one cycle without losing registers retired after the branch dispatched.

---
 rtl/fl_checkpoint_stack.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/fl_checkpoint_stack.sv
`default_nettype none
// ============================================================================
//  Module      : fl_checkpoint_stack
//  Description : Branch checkpoint store for the physical-register free list.
//                Snapshots the free list on branch dispatch, keeps appending
//                retired T_old tags to every live snapshot, and drives a
//                single-cycle restore into the free list on a mispredict.
//  Revision    : 1.0 - initial release
// ============================================================================
module fl_checkpoint_stack #(
    parameter int NUM_PHYS_REG = 32,
    parameter int FL_SIZE      = NUM_PHYS_REG,
    parameter int PR_W         = $clog2(NUM_PHYS_REG),
    parameter int NUM_CKPT     = 4
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                branch_dispatch,
    input  logic [FL_SIZE-1:0][PR_W-1:0]        fl_snap,
    input  logic [$clog2(FL_SIZE):0]            tail_snap,
    input  logic                                retire_en,
    input  logic [PR_W-1:0]                     T_old,
    input  logic                                resolve_en,
    input  logic [$clog2(NUM_CKPT)-1:0]         resolve_tag,
    input  logic                                resolve_incorrect,
    output logic [$clog2(NUM_CKPT)-1:0]         alloc_tag,
    output logic                                full,
    output logic [$clog2(NUM_CKPT):0]           num_ckpt,
    output logic                                branch_incorrect,
    output logic [FL_SIZE-1:0][PR_W-1:0]        free_check_point,
    output logic [$clog2(FL_SIZE):0]            tail_check_point
);

    localparam int c_TAG_W  = $clog2(NUM_CKPT);
    localparam int c_IDX_W  = $clog2(FL_SIZE);
    localparam int c_TAIL_W = c_IDX_W + 1;
    localparam int c_CNT_W  = c_TAG_W + 1;
    localparam logic [c_TAIL_W-1:0] c_TAIL_FULL = c_TAIL_W'(FL_SIZE);

    // Slot bookkeeping; list/tail contents are only meaningful while valid.
    logic [NUM_CKPT-1:0]                r_valid;
    logic [c_TAG_W-1:0]                 r_alloc_ptr;
    logic [FL_SIZE-1:0][PR_W-1:0]       r_list [NUM_CKPT];
    logic [c_TAIL_W-1:0]                r_tail [NUM_CKPT];

    logic                               w_recover;
    logic                               w_resolve_ok;
    logic                               w_alloc;
    logic [c_TAG_W-1:0]                 w_dist_alloc;
    logic [NUM_CKPT-1:0]                w_squash;
    logic [c_CNT_W-1:0]                 w_count;
    logic [FL_SIZE-1:0][PR_W-1:0]       w_ckpt_list;
    logic [c_TAIL_W-1:0]                w_ckpt_tail;

    // Resolves against an invalid slot are dropped; recover beats allocate.
    assign w_recover    = resolve_en &  resolve_incorrect & r_valid[resolve_tag];
    assign w_resolve_ok = resolve_en & ~resolve_incorrect & r_valid[resolve_tag];
    assign w_alloc      = branch_dispatch & ~full & ~w_recover;

    assign full             = r_valid[r_alloc_ptr];
    assign alloc_tag        = r_alloc_ptr;
    assign num_ckpt         = w_count;
    assign branch_incorrect = w_recover;
    assign free_check_point = w_ckpt_list;
    assign tail_check_point = w_ckpt_tail;

    // Squash set: the mispredicted slot and everything younger, i.e. slots
    // whose circular distance from the tag is below that of alloc_ptr. A zero
    // distance with a valid tag means the ring is full and the tag is the
    // oldest entry, so every slot goes.
    always_comb begin
        w_dist_alloc = r_alloc_ptr - resolve_tag;
        w_squash     = '0;
        for (int i = 0; i < NUM_CKPT; i++) begin
            if (w_recover &&
                ((w_dist_alloc == '0) ||
                 ((c_TAG_W'(i) - resolve_tag) < w_dist_alloc))) begin
                w_squash[i] = 1'b1;
            end
        end
    end

    // Live checkpoint count.
    always_comb begin
        w_count = '0;
        for (int i = 0; i < NUM_CKPT; i++) begin
            w_count = w_count + c_CNT_W'(r_valid[i]);
        end
    end

    // Restore data, including a T_old retiring in the same cycle as the mispredict.
    always_comb begin
        w_ckpt_list = '0;
        w_ckpt_tail = '0;
        if (w_recover) begin
            w_ckpt_list = r_list[resolve_tag];
            w_ckpt_tail = r_tail[resolve_tag];
            if (retire_en && (r_tail[resolve_tag] < c_TAIL_FULL)) begin
                w_ckpt_list[r_tail[resolve_tag][c_IDX_W-1:0]] = T_old;
                w_ckpt_tail = r_tail[resolve_tag] + c_TAIL_W'(1);
            end
        end
    end

    // Slot valid bits and allocation pointer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_valid     <= '0;
            r_alloc_ptr <= '0;
        end else begin
            for (int i = 0; i < NUM_CKPT; i++) begin
                if (w_squash[i]) begin
                    r_valid[i] <= 1'b0;
                end else if (w_resolve_ok && (resolve_tag == c_TAG_W'(i))) begin
                    r_valid[i] <= 1'b0;
                end else if (w_alloc && (r_alloc_ptr == c_TAG_W'(i))) begin
                    r_valid[i] <= 1'b1;
                end
            end
            if (w_recover) begin
                r_alloc_ptr <= resolve_tag;
            end else if (w_alloc) begin
                r_alloc_ptr <= r_alloc_ptr + c_TAG_W'(1);
            end
        end
    end

    // Snapshot capture and retire append into surviving slots (saturating).
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_CKPT; i++) begin
            if (w_alloc && (r_alloc_ptr == c_TAG_W'(i))) begin
                r_list[i] <= fl_snap;
                r_tail[i] <= tail_snap;
            end else if (retire_en && r_valid[i] && !w_squash[i] &&
                         (r_tail[i] < c_TAIL_FULL)) begin
                r_list[i][r_tail[i][c_IDX_W-1:0]] <= T_old;
                r_tail[i] <= r_tail[i] + c_TAIL_W'(1);
            end
        end
    end

endmodule
`default_nettype wire
